// File: rtl/text_ram_writer_if.sv
// Command handshake between a text source and the character-RAM writer.
// Fields are only meaningful on a cycle where cmd_valid && cmd_ready.
interface text_ram_writer_if #(
  parameter int DATA_W = 8,
  parameter int ROW_W  = 5,
  parameter int COL_W  = 7
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic [ROW_W-1:0]  cmd_row;
  logic [COL_W-1:0]  cmd_col;

  modport master (output cmd_valid, cmd_op, cmd_data, cmd_row, cmd_col, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_data, cmd_row, cmd_col, output cmd_ready);
endinterface

// File: rtl/text_ram_writer.sv
// Command-driven writer for the text-overlay character RAM: put / set cursor /
// clear, with a row/column cursor and a registered single-cycle write port.
module text_ram_writer #(
  parameter int              COLS      = 80,
  parameter int              ROWS      = 25,
  parameter int              ADDR_W    = 11,
  parameter int              DATA_W    = 8,
  parameter logic [DATA_W-1:0] FILL_CHAR = 8'h20,
  parameter logic [DATA_W-1:0] NL_CHAR   = 8'h0A,
  localparam int             ROW_W     = $clog2(ROWS),
  localparam int             COL_W     = $clog2(COLS)
) (
  input  logic                clk,
  input  logic                rst_n,
  text_ram_writer_if.slave    cmd,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   din,
  output logic                ram_en,
  output logic [ROW_W-1:0]    cur_row,
  output logic [COL_W-1:0]    cur_col
);
  typedef enum logic {IDLE, CLEAR} state_t;
  typedef enum logic [1:0] {OP_PUT, OP_SET, OP_CLR, OP_NOP} op_t;

  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(COLS * ROWS - 1);

  state_t             state, state_d;
  logic [ADDR_W-1:0]  lin, lin_d;        // cur_row*COLS + cur_col, tracked incrementally
  logic [ADDR_W-1:0]  addr_d;
  logic [DATA_W-1:0]  din_d;
  logic               en_d;
  logic [ROW_W-1:0]   row_d;
  logic [COL_W-1:0]   col_d;
  logic               set_ok;

  assign cmd.cmd_ready = (state == IDLE);
  assign set_ok = ({1'b0, cmd.cmd_row} < (ROW_W+1)'(ROWS)) &&
                  ({1'b0, cmd.cmd_col} < (COL_W+1)'(COLS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr    <= '0;
      din     <= '0;
      ram_en  <= 1'b0;
      cur_row <= '0;
      cur_col <= '0;
      lin     <= '0;
    end else begin
      state   <= state_d;
      addr    <= addr_d;
      din     <= din_d;
      ram_en  <= en_d;
      cur_row <= row_d;
      cur_col <= col_d;
      lin     <= lin_d;
    end
  end

  always_comb begin
    state_d = state;
    addr_d  = addr;
    din_d   = din;
    en_d    = 1'b0;
    row_d   = cur_row;
    col_d   = cur_col;
    lin_d   = lin;
    case (state)
      IDLE: if (cmd.cmd_valid) begin
        case (op_t'(cmd.cmd_op))
          OP_PUT: begin
            // Both paths leave the cursor on the next cell; only the screen end wraps lin to 0.
            if (cmd.cmd_data != NL_CHAR) begin
              en_d   = 1'b1;
              addr_d = lin;
              din_d  = cmd.cmd_data;
              if (cur_col == COL_LAST) begin
                col_d = '0;
                if (cur_row == ROW_LAST) begin
                  row_d = '0;
                  lin_d = '0;
                end else begin
                  row_d = cur_row + ROW_W'(1);
                  lin_d = lin + ADDR_W'(1);
                end
              end else begin
                col_d = cur_col + COL_W'(1);
                lin_d = lin + ADDR_W'(1);
              end
            end else begin
              col_d = '0;
              if (cur_row == ROW_LAST) begin
                row_d = '0;
                lin_d = '0;
              end else begin
                row_d = cur_row + ROW_W'(1);
                lin_d = lin + ADDR_W'(COLS) - ADDR_W'(cur_col);
              end
            end
          end
          OP_SET: if (set_ok) begin
            row_d = cmd.cmd_row;
            col_d = cmd.cmd_col;
            lin_d = ADDR_W'(cmd.cmd_row) * ADDR_W'(COLS) + ADDR_W'(cmd.cmd_col);
          end
          OP_CLR: begin
            state_d = CLEAR;
            en_d    = 1'b1;
            addr_d  = '0;
            din_d   = FILL_CHAR;
          end
          default: ;
        endcase
      end
      CLEAR: begin
        // addr doubles as the fill counter; din already holds FILL_CHAR.
        if (addr == ADDR_LAST) begin
          state_d = IDLE;
          row_d   = '0;
          col_d   = '0;
          lin_d   = '0;
        end else begin
          en_d   = 1'b1;
          addr_d = addr + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_text_ram_writer.sv
// Randomised self-checking bench for text_ram_writer against a row/column cursor model.
module tb_text_ram_writer;
  localparam int COLS = 80, ROWS = 25, ADDR_W = 11, DATA_W = 8;
  localparam int ROW_W = 5, COL_W = 7;
  localparam logic [1:0] PUT = 2'b00, SET = 2'b01, CLR = 2'b10, NOP = 2'b11;
  localparam logic [7:0] NL = 8'h0A, FILL = 8'h20;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic ram_en;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] cur_col;
  int checks = 0, errors = 0;
  int m_row = 0, m_col = 0;

  text_ram_writer_if #(.DATA_W(DATA_W), .ROW_W(ROW_W), .COL_W(COL_W)) cif();

  text_ram_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cif), .addr(addr), .din(din),
    .ram_en(ram_en), .cur_row(cur_row), .cur_col(cur_col));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference: cursor as plain integers, address by multiplication.
  task automatic model_cmd(input logic [1:0] op, input logic [7:0] d, input int r, input int c,
                           output bit en, output int a);
    en = 0; a = 0;
    case (op)
      PUT: if (d != NL) begin
        en = 1; a = m_row * COLS + m_col;
        m_col++;
        if (m_col == COLS) begin m_col = 0; m_row = (m_row + 1) % ROWS; end
      end else begin
        m_col = 0; m_row = (m_row + 1) % ROWS;
      end
      SET: if (r < ROWS && c < COLS) begin m_row = r; m_col = c; end
      default: ;
    endcase
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] d, input int r, input int c);
    @(negedge clk);
    cif.cmd_valid = 1'b1; cif.cmd_op = op; cif.cmd_data = d;
    cif.cmd_row = ROW_W'(r); cif.cmd_col = COL_W'(c);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    checks++;
    if (addr !== 0 || din !== 0 || ram_en !== 0 || cur_row !== 0 || cur_col !== 0 || cif.cmd_ready !== 1) begin
      errors++;
      $display("FAIL reset addr=%0d din=%0h en=%0b row=%0d col=%0d rdy=%0b exp all 0, rdy 1",
               addr, din, ram_en, cur_row, cur_col, cif.cmd_ready);
    end
  endtask

  task automatic test_put_basic();
    bit en; int a;
    send(SET, 0, 10, 0); model_cmd(SET, 0, 10, 0, en, a);
    checks++;
    if (ram_en !== 0 || cur_row !== m_row || cur_col !== m_col) begin
      errors++; $display("FAIL set_cursor en=%0b row=%0d col=%0d exp en=0 row=%0d col=%0d", ram_en, cur_row, cur_col, m_row, m_col);
    end
    send(PUT, 8'h61, 0, 0); model_cmd(PUT, 8'h61, 0, 0, en, a);
    checks++;
    if (ram_en !== 1 || addr !== 800 || din !== 8'h61 || cur_row !== 10 || cur_col !== 1) begin
      errors++; $display("FAIL put_basic en=%0b addr=%0d din=%0h row=%0d col=%0d exp 1/800/61/10/1", ram_en, addr, din, cur_row, cur_col);
    end
    idle();
    checks++;
    if (ram_en !== 0) begin errors++; $display("FAIL put_drop en=%0b exp 0", ram_en); end
  endtask

  task automatic test_back_to_back();
    bit en; int a;
    logic [7:0] s [3];
    s[0] = 8'h41; s[1] = 8'h42; s[2] = 8'h43;
    send(SET, 0, 0, 78); model_cmd(SET, 0, 0, 78, en, a);
    for (int i = 0; i < 3; i++) begin
      send(PUT, s[i], 0, 0); model_cmd(PUT, s[i], 0, 0, en, a);
      checks++;
      if (ram_en !== 1 || addr !== ADDR_W'(a) || din !== s[i] || a != 78 + i) begin
        errors++; $display("FAIL b2b_%0d en=%0b addr=%0d din=%0h exp 1/%0d/%0h", i, ram_en, addr, din, 78 + i, s[i]);
      end
    end
    checks++;
    if (cur_row !== 1 || cur_col !== 1) begin
      errors++; $display("FAIL b2b_cursor row=%0d col=%0d exp 1/1", cur_row, cur_col);
    end
    idle();
  endtask

  task automatic test_newline();
    bit en; int a;
    send(SET, 0, 3, 5); model_cmd(SET, 0, 3, 5, en, a);
    send(PUT, NL, 0, 0); model_cmd(PUT, NL, 0, 0, en, a);
    checks++;
    if (ram_en !== 0 || cur_row !== 4 || cur_col !== 0) begin
      errors++; $display("FAIL newline en=%0b row=%0d col=%0d exp 0/4/0", ram_en, cur_row, cur_col);
    end
    send(PUT, 8'h31, 0, 0); model_cmd(PUT, 8'h31, 0, 0, en, a);
    checks++;
    if (ram_en !== 1 || addr !== 320) begin
      errors++; $display("FAIL newline_put en=%0b addr=%0d exp 1/320", ram_en, addr);
    end
    send(SET, 0, 24, 40); model_cmd(SET, 0, 24, 40, en, a);
    send(PUT, NL, 0, 0); model_cmd(PUT, NL, 0, 0, en, a);
    checks++;
    if (ram_en !== 0 || cur_row !== 0 || cur_col !== 0) begin
      errors++; $display("FAIL newline_wrap en=%0b row=%0d col=%0d exp 0/0/0", ram_en, cur_row, cur_col);
    end
    idle();
  endtask

  task automatic test_wrap();
    bit en; int a;
    send(SET, 0, 24, 79); model_cmd(SET, 0, 24, 79, en, a);
    send(PUT, 8'h5A, 0, 0); model_cmd(PUT, 8'h5A, 0, 0, en, a);
    checks++;
    if (ram_en !== 1 || addr !== 1999 || din !== 8'h5A || cur_row !== 0 || cur_col !== 0) begin
      errors++; $display("FAIL wrap_put en=%0b addr=%0d din=%0h row=%0d col=%0d exp 1/1999/5a/0/0", ram_en, addr, din, cur_row, cur_col);
    end
    send(PUT, 8'h5B, 0, 0); model_cmd(PUT, 8'h5B, 0, 0, en, a);
    checks++;
    if (ram_en !== 1 || addr !== 0) begin
      errors++; $display("FAIL wrap_next en=%0b addr=%0d exp 1/0", ram_en, addr);
    end
    send(SET, 0, 25, 0); model_cmd(SET, 0, 25, 0, en, a);
    checks++;
    if (ram_en !== 0 || cur_row !== 0 || cur_col !== 1 || cif.cmd_ready !== 1) begin
      errors++; $display("FAIL set_oob en=%0b row=%0d col=%0d exp 0/0/1", ram_en, cur_row, cur_col);
    end
    idle();
  endtask

  task automatic test_random();
    bit en; int a; int r, c, sel;
    logic [1:0] op; logic [7:0] d;
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      op  = (sel < 6) ? PUT : (sel < 8) ? SET : (sel == 8) ? NOP : PUT;
      d   = (sel == 9) ? NL : 8'($urandom_range(0, 255));
      r   = $urandom_range(0, 31);
      c   = $urandom_range(0, 127);
      send(op, d, r, c); model_cmd(op, d, r, c, en, a);
      checks++;
      if (ram_en !== en || (en && (addr !== ADDR_W'(a) || din !== d)) || cur_row !== m_row || cur_col !== m_col) begin
        errors++;
        $display("FAIL rand_%0d op=%0d en=%0b addr=%0d din=%0h row=%0d col=%0d exp en=%0b addr=%0d din=%0h row=%0d col=%0d",
                 i, op, ram_en, addr, din, cur_row, cur_col, en, a, d, m_row, m_col);
      end
      if ($urandom_range(0, 3) == 0) begin
        idle();
        checks++;
        if (ram_en !== 0) begin errors++; $display("FAIL rand_gap_%0d en=%0b exp 0", i, ram_en); end
      end
    end
    idle();
  endtask

  task automatic test_clear();
    bit en; int a;
    send(CLR, 0, 0, 0);
    cif.cmd_op = PUT; cif.cmd_data = 8'h51;  // held behind the clear
    for (int k = 0; k < COLS * ROWS; k++) begin
      checks++;
      if (ram_en !== 1 || addr !== ADDR_W'(k) || din !== FILL || cif.cmd_ready !== 0) begin
        errors++; $display("FAIL clear_%0d en=%0b addr=%0d din=%0h rdy=%0b exp 1/%0d/20/0", k, ram_en, addr, din, cif.cmd_ready, k);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (cif.cmd_ready !== 1 || ram_en !== 0 || cur_row !== 0 || cur_col !== 0) begin
      errors++; $display("FAIL clear_end rdy=%0b en=%0b row=%0d col=%0d exp 1/0/0/0", cif.cmd_ready, ram_en, cur_row, cur_col);
    end
    m_row = 0; m_col = 0;
    @(posedge clk); #1;
    model_cmd(PUT, 8'h51, 0, 0, en, a);
    checks++;
    if (ram_en !== 1 || addr !== 0 || din !== 8'h51 || cur_row !== 0 || cur_col !== 1) begin
      errors++; $display("FAIL clear_pending en=%0b addr=%0d din=%0h row=%0d col=%0d exp 1/0/51/0/1", ram_en, addr, din, cur_row, cur_col);
    end
    idle();
  endtask

  task automatic test_reset_mid_clear();
    int writes = 0;
    send(SET, 0, 7, 7);
    send(CLR, 0, 0, 0);
    cif.cmd_valid = 1'b0;
    repeat (500) begin @(posedge clk); #1; end
    checks++;
    if (ram_en !== 1 || addr !== 500) begin
      errors++; $display("FAIL mid_clear en=%0b addr=%0d exp 1/500", ram_en, addr);
    end
    rst_n = 1'b0; #1;
    checks++;
    if (ram_en !== 0 || addr !== 0 || din !== 0) begin
      errors++; $display("FAIL rst_abort en=%0b addr=%0d din=%0h exp 0/0/0", ram_en, addr, din);
    end
    repeat (3) begin @(posedge clk); #1; if (ram_en) writes++; end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; if (ram_en) writes++; end
    checks++;
    if (writes != 0 || cif.cmd_ready !== 1 || cur_row !== 0 || cur_col !== 0) begin
      errors++; $display("FAIL rst_after writes=%0d rdy=%0b row=%0d col=%0d exp 0/1/0/0", writes, cif.cmd_ready, cur_row, cur_col);
    end
    m_row = 0; m_col = 0;
  endtask

  initial begin
    cif.cmd_valid = 1'b0; cif.cmd_op = NOP; cif.cmd_data = '0; cif.cmd_row = '0; cif.cmd_col = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_put_basic();
    test_back_to_back();
    test_newline();
    test_wrap();
    test_random();
    test_clear();
    test_random();
    test_reset_mid_clear();
    test_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
